// File: rtl/output_port_allocator.sv
// ---------------------------------------------------------------------------
// output_port_allocator
//
// Round-robin switch allocator for one output direction of a mesh NoC router.
// Each cycle it picks one of the five input ports whose route direction
// selects this output. It registers the winning 32-bit single-flit packet
// onto the output link and tracks free downstream buffer slots with a credit
// counter.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid[5]    input port i holds a packet
//   in_packet[160] packet of port i at [32*i +: 32]
//   in_dir[15]     route direction of port i at [3*i +: 3]
//   in_ready[5]    one-hot grant; the packet of that port is consumed this cycle
//   out_valid      out_packet/out_src carry a packet this cycle
//   out_packet[32] granted packet, registered
//   out_src[3]     index of the input that supplied out_packet
//   credit_return  downstream freed one buffer slot
//   credit_count[4] credits currently available
//   credit_err     sticky flag: a credit was returned while the counter was full
// ---------------------------------------------------------------------------
module output_port_allocator #(
    parameter logic [2:0] PORT_DIR   = 3'd0,
    parameter int         CREDITS    = 4,
    parameter int         NUM_INPUTS = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [4:0]   in_valid,
    input  logic [159:0] in_packet,
    input  logic [14:0]  in_dir,
    output logic [4:0]   in_ready,
    output logic         out_valid,
    output logic [31:0]  out_packet,
    output logic [2:0]   out_src,
    input  logic         credit_return,
    output logic [3:0]   credit_count,
    output logic         credit_err
);

    localparam logic [3:0] CREDIT_MAX = 4'(CREDITS);

    logic [4:0]  req;
    logic [2:0]  rr_ptr;
    logic [2:0]  win;
    logic        found;
    logic        grant;
    logic [31:0] sel_packet;

    // Saturating credit update: a return at full count is absorbed (and
    // flagged separately), a grant at zero cannot happen because grant is
    // already gated on a nonzero count.
    function automatic logic [3:0] next_credit(input logic [3:0] cnt,
                                               input logic       take,
                                               input logic       give);
        logic [3:0] nxt;
        nxt = cnt;
        if (take && !give) begin
            nxt = cnt - 4'd1;
        end else if (give && !take && cnt != CREDIT_MAX) begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

    // Stage 0: request decode and combinational round-robin arbitration
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            req[i] = in_valid[i] && (in_dir[3*i +: 3] == PORT_DIR);
        end
    end

    // Scan starting at rr_ptr, wrapping 4 -> 0; the first requester wins.
    always_comb begin
        logic [3:0] pos;
        found = 1'b0;
        win   = 3'd0;
        pos   = 4'd0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            pos = {1'b0, rr_ptr} + 4'(k);
            if (pos >= 4'(NUM_INPUTS)) begin
                pos = pos - 4'(NUM_INPUTS);
            end
            if (!found && req[pos[2:0]]) begin
                found = 1'b1;
                win   = pos[2:0];
            end
        end
    end

    // rst_n gates the grant so no packet is acknowledged while reset is held.
    assign grant = found && (credit_count != 4'd0) && rst_n;

    // Only the granted port's data is selected, so idle ports cannot leak
    // unknown values onto the link.
    always_comb begin
        in_ready   = '0;
        sel_packet = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant && win == 3'(i)) begin
                in_ready[i] = 1'b1;
                sel_packet  = in_packet[32*i +: 32];
            end
        end
    end

    // Stage 1: output link register, round-robin pointer and credits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_packet   <= '0;
            out_src      <= '0;
            rr_ptr       <= '0;
            credit_count <= CREDIT_MAX;
            credit_err   <= 1'b0;
        end else begin
            out_valid    <= grant;
            credit_count <= next_credit(credit_count, grant, credit_return);
            if (grant) begin
                out_packet <= sel_packet;
                out_src    <= win;
                rr_ptr     <= (win == 3'(NUM_INPUTS - 1)) ? 3'd0 : win + 3'd1;
            end
            if (credit_return && !grant && credit_count == CREDIT_MAX) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule
